// File: rtl/scan_decode_n_pkg.sv
// Shared types and helpers for the scanning one-hot decoder family.
package decode_pkg;

    typedef logic [1:0] state_t;

    localparam state_t StIdle   = 2'd0;
    localparam state_t StDirect = 2'd1;
    localparam state_t StScan   = 2'd2;

    // Widest decoder any instance may use; onehot() returns this many bits.
    localparam int unsigned MaxN    = 8;
    localparam int unsigned MaxOutW = 2 ** MaxN;

    function automatic int unsigned out_w(input int unsigned n);
        return 2 ** n;
    endfunction

    function automatic logic [MaxOutW-1:0] onehot(input int unsigned idx);
        return MaxOutW'(1) << idx;
    endfunction

endpackage

// File: rtl/scan_decode_n_if.sv
// Control inputs and registered select outputs of scan_decode_n.
interface scan_decode_n_if #(
    parameter int unsigned N = 3
) ();
    localparam int unsigned OutW = 2 ** N;

    logic            en;
    logic            mode;
    logic [N-1:0]    x;
    logic [N-1:0]    scan_last;
    logic [OutW-1:0] y;
    logic [N-1:0]    idx;
    logic            wrap;

    modport master (
        output en, mode, x, scan_last,
        input  y, idx, wrap
    );

    modport slave (
        input  en, mode, x, scan_last,
        output y, idx, wrap
    );
endinterface

// File: rtl/scan_decode_n_decode_n.sv
// Combinational N-to-2^N one-hot decoder with enable; all zeros when disabled.
module decode_n
    import decode_pkg::*;
#(
    parameter int unsigned N = 3
) (
    input  logic            en,
    input  logic [N-1:0]    sel,
    output logic [2**N-1:0] y
);
    localparam int unsigned OutW = out_w(N);

    logic [MaxOutW-1:0] oh_full;

    always_comb oh_full = onehot(32'(sel));

    assign y = en ? oh_full[OutW-1:0] : '0;

    if (OutW < MaxOutW) begin : g_unused
        logic unused_hi;
        assign unused_hi = ^oh_full[MaxOutW-1:OutW];
    end
endmodule

// File: rtl/scan_decode_n.sv
// Registered one-hot select driver: direct decode of x, or a timed scan 0..scan_last.
module scan_decode_n
    import decode_pkg::*;
#(
    parameter int unsigned N          = 3,
    parameter int unsigned DWELL      = 4,
    parameter bit          ACTIVE_LOW = 1'b0
) (
    input logic           clk,
    input logic           rst_n,
    scan_decode_n_if.slave bus
);
    localparam int unsigned OUT_W = out_w(N);
    localparam int unsigned DW    = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [DW-1:0] DwellLast = DW'(DWELL - 1);

    state_t          state_q, state_d;
    logic [N-1:0]    idx_q, idx_d;
    logic [DW-1:0]   dwell_q, dwell_d;
    logic            wrap_q, wrap_d;
    logic [OUT_W-1:0] oh_q, oh_d;
    logic            dec_en;

    always_comb begin
        state_d = !bus.en ? StIdle : (bus.mode ? StScan : StDirect);
        idx_d   = '0;
        dwell_d = '0;
        wrap_d  = 1'b0;
        case (state_d)
            StDirect: idx_d = bus.x;
            StScan: begin
                // Entering SCAN keeps the zeroed defaults so the sweep restarts at 0.
                if (state_q == StScan) begin
                    if (dwell_q == DwellLast) begin
                        if (idx_q >= bus.scan_last) begin
                            wrap_d = 1'b1;
                        end else begin
                            idx_d = idx_q + 1'b1;
                        end
                    end else begin
                        dwell_d = dwell_q + 1'b1;
                        idx_d   = idx_q;
                    end
                end
            end
            default: ;
        endcase
    end

    assign dec_en = (state_d != StIdle);

    decode_n #(
        .N (N)
    ) u_decode (
        .en  (dec_en),
        .sel (idx_d),
        .y   (oh_d)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            idx_q   <= '0;
            dwell_q <= '0;
            wrap_q  <= 1'b0;
            oh_q    <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            dwell_q <= dwell_d;
            wrap_q  <= wrap_d;
            oh_q    <= oh_d;
        end
    end

    assign bus.y    = ACTIVE_LOW ? ~oh_q : oh_q;
    assign bus.idx  = idx_q;
    assign bus.wrap = wrap_q;
endmodule

// File: tb/tb_scan_decode_n.sv
// Self-checking bench: DUT A (DWELL=4, active-high) and DUT B (DWELL=1, active-low).
module tb_scan_decode_n;
    localparam int unsigned N = 3;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    scan_decode_n_if #(.N(N)) bus_a ();
    scan_decode_n_if #(.N(N)) bus_b ();

    scan_decode_n #(.N(N), .DWELL(4), .ACTIVE_LOW(1'b0)) u_dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_a)
    );

    scan_decode_n #(.N(N), .DWELL(1), .ACTIVE_LOW(1'b1)) u_dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_b)
    );

    int vectors = 0;
    int miscompares = 0;

    // Reference model: position shown, how many cycles it has been shown, scan/active flags.
    int m_idx[2];
    int m_held[2];
    bit m_act[2];
    bit m_scan[2];
    bit m_wrap[2];

    function automatic int dwell_of(input int d);
        return (d == 0) ? 4 : 1;
    endfunction

    function automatic void model_reset();
        for (int d = 0; d < 2; d++) begin
            m_idx[d] = 0; m_held[d] = 0; m_act[d] = 0; m_scan[d] = 0; m_wrap[d] = 0;
        end
    endfunction

    function automatic void model_step(input int d, input bit en, input bit mode,
                                       input int x, input int sl);
        m_wrap[d] = 0;
        if (!en) begin
            m_act[d] = 0; m_scan[d] = 0; m_idx[d] = 0; m_held[d] = 0;
        end else if (!mode) begin
            m_act[d] = 1; m_scan[d] = 0; m_idx[d] = x; m_held[d] = 0;
        end else if (!m_scan[d]) begin
            m_act[d] = 1; m_scan[d] = 1; m_idx[d] = 0; m_held[d] = 1;
        end else if (m_held[d] < dwell_of(d)) begin
            m_held[d]++;
        end else begin
            m_held[d] = 1;
            if (m_idx[d] >= sl) begin
                m_idx[d] = 0;
                m_wrap[d] = 1;
            end else begin
                m_idx[d]++;
            end
        end
    endfunction

    function automatic logic [11:0] expect_of(input int d);
        logic [7:0] e;
        e = m_act[d] ? 8'(1 << m_idx[d]) : 8'h00;
        if (d == 1) e = ~e;
        return {e, 3'(m_idx[d]), m_wrap[d]};
    endfunction

    task automatic tick();
        @(posedge clk);
        if (rst_n) begin
            model_step(0, bus_a.en, bus_a.mode, int'(bus_a.x), int'(bus_a.scan_last));
            model_step(1, bus_b.en, bus_b.mode, int'(bus_b.x), int'(bus_b.scan_last));
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        logic [11:0] got;
        rst_n = 1'b0;
        bus_a.en = 0; bus_a.mode = 0; bus_a.x = '0; bus_a.scan_last = '0;
        bus_b.en = 0; bus_b.mode = 0; bus_b.x = '0; bus_b.scan_last = '0;
        model_reset();
        #1;
        got = {bus_a.y, bus_a.idx, bus_a.wrap};
        vectors++;
        if (got !== 12'h000) begin
            miscompares++; $display("FAIL reset_a: got %h want %h", got, 12'h000);
        end
        got = {bus_b.y, bus_b.idx, bus_b.wrap};
        vectors++;
        if (got !== {8'hFF, 3'd0, 1'b0}) begin
            miscompares++; $display("FAIL reset_b: got %h want %h", got, {8'hFF, 4'h0});
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        bus_a.en = 1; bus_a.mode = 1; bus_a.scan_last = 3'd7;
        for (int i = 0; i < 10; i++) begin
            tick();
            got = {bus_a.y, bus_a.idx, bus_a.wrap};
            vectors++;
            if (got !== expect_of(0)) begin
                miscompares++; $display("FAIL reset_prescan cyc %0d: got %h want %h", i, got, expect_of(0));
            end
        end
        // Assert reset between edges; outputs must clear without a clock.
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        got = {bus_a.y, bus_a.idx, bus_a.wrap};
        vectors++;
        if (got !== 12'h000) begin
            miscompares++; $display("FAIL reset_async: got %h want %h", got, 12'h000);
        end
        bus_a.en = 0; bus_a.mode = 0;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_direct();
        logic [11:0] got;
        bus_a.en = 1; bus_a.mode = 0; bus_a.x = 3'd5;
        tick();
        got = {bus_a.y, bus_a.idx, bus_a.wrap};
        vectors++;
        if (got !== {8'h20, 3'd5, 1'b0}) begin
            miscompares++; $display("FAIL direct_x5: got %h want %h", got, {8'h20, 3'd5, 1'b0});
        end
        bus_a.x = 3'd2;
        tick();
        got = {bus_a.y, bus_a.idx, bus_a.wrap};
        vectors++;
        if (got !== {8'h04, 3'd2, 1'b0}) begin
            miscompares++; $display("FAIL direct_x2: got %h want %h", got, {8'h04, 3'd2, 1'b0});
        end
        for (int i = 0; i < 20; i++) begin
            bus_a.x = 3'($urandom_range(0, 7));
            tick();
            got = {bus_a.y, bus_a.idx, bus_a.wrap};
            vectors++;
            if (got !== expect_of(0)) begin
                miscompares++; $display("FAIL direct_rand cyc %0d: got %h want %h", i, got, expect_of(0));
            end
        end
    endtask

    task automatic test_scan_full();
        logic [11:0] got;
        int wraps = 0;
        int first_wrap = -1;
        bus_a.mode = 1; bus_a.scan_last = 3'd7;
        for (int c = 0; c <= 64; c++) begin
            tick();
            got = {bus_a.y, bus_a.idx, bus_a.wrap};
            vectors++;
            if (got !== expect_of(0)) begin
                miscompares++; $display("FAIL scan_full cyc %0d: got %h want %h", c, got, expect_of(0));
            end
            if (bus_a.wrap === 1'b1) begin
                wraps++;
                if (first_wrap < 0) first_wrap = c;
            end
        end
        vectors++;
        if (wraps != 2 || first_wrap != 32) begin
            miscompares++;
            $display("FAIL scan_full_period: got wraps %0d first %0d want 2 at 32", wraps, first_wrap);
        end
    endtask

    task automatic test_limit();
        logic [11:0] got;
        int guard = 0;
        bit saw_wrap = 0;
        int wraps = 0;
        while (m_idx[0] != 6 && guard < 40) begin
            tick();
            guard++;
        end
        vectors++;
        if (m_idx[0] != 6 || bus_a.idx !== 3'd6) begin
            miscompares++; $display("FAIL limit_reach6: got idx %0d want 6", bus_a.idx);
        end
        bus_a.scan_last = 3'd3;
        for (int i = 0; i < 4; i++) begin
            tick();
            got = {bus_a.y, bus_a.idx, bus_a.wrap};
            vectors++;
            if (got !== expect_of(0)) begin
                miscompares++; $display("FAIL limit_lower cyc %0d: got %h want %h", i, got, expect_of(0));
            end
            if (bus_a.wrap === 1'b1 && bus_a.idx === 3'd0) saw_wrap = 1;
        end
        vectors++;
        if (saw_wrap !== 1'b1) begin
            miscompares++; $display("FAIL limit_wrap: got %0b want 1", saw_wrap);
        end
        bus_a.scan_last = 3'd0;
        for (int i = 0; i < 16; i++) begin
            tick();
            got = {bus_a.y, bus_a.idx, bus_a.wrap};
            vectors++;
            if (got !== expect_of(0) || bus_a.y !== 8'h01) begin
                miscompares++; $display("FAIL limit_zero cyc %0d: got %h want %h", i, got, expect_of(0));
            end
            if (bus_a.wrap === 1'b1) wraps++;
        end
        vectors++;
        if (wraps != 4) begin
            miscompares++; $display("FAIL limit_zero_wraps: got %0d want 4", wraps);
        end
    endtask

    task automatic test_mode_en();
        logic [11:0] got;
        int guard = 0;
        bus_a.scan_last = 3'd7;
        while (!(m_idx[0] == 4 && m_held[0] == 2) && guard < 80) begin
            tick();
            guard++;
        end
        vectors++;
        if (bus_a.idx !== 3'd4) begin
            miscompares++; $display("FAIL mode_reach4: got idx %0d want 4", bus_a.idx);
        end
        bus_a.mode = 0; bus_a.x = 3'd1;
        tick();
        got = {bus_a.y, bus_a.idx, bus_a.wrap};
        vectors++;
        if (got !== {8'h02, 3'd1, 1'b0}) begin
            miscompares++; $display("FAIL mode_to_direct: got %h want %h", got, {8'h02, 3'd1, 1'b0});
        end
        bus_a.mode = 1;
        for (int i = 0; i < 5; i++) begin
            tick();
            got = {bus_a.y, bus_a.idx, bus_a.wrap};
            vectors++;
            if (got !== {(i < 4) ? 8'h01 : 8'h02, (i < 4) ? 3'd0 : 3'd1, 1'b0}) begin
                miscompares++; $display("FAIL mode_restart cyc %0d: got %h want %h", i, got, expect_of(0));
            end
        end
        bus_a.en = 0;
        tick();
        got = {bus_a.y, bus_a.idx, bus_a.wrap};
        vectors++;
        if (got !== 12'h000) begin
            miscompares++; $display("FAIL en_off: got %h want %h", got, 12'h000);
        end
    endtask

    task automatic test_fast_active_low();
        logic [11:0] got;
        bus_b.en = 1; bus_b.mode = 1; bus_b.scan_last = 3'd7;
        for (int i = 0; i < 18; i++) begin
            tick();
            got = {bus_b.y, bus_b.idx, bus_b.wrap};
            vectors++;
            if (got !== expect_of(1) || bus_b.y !== ~8'(1 << (i % 8))) begin
                miscompares++; $display("FAIL fast_al cyc %0d: got %h want %h", i, got, expect_of(1));
            end
        end
        bus_b.en = 0;
        tick();
        got = {bus_b.y, bus_b.idx, bus_b.wrap};
        vectors++;
        if (got !== {8'hFF, 3'd0, 1'b0}) begin
            miscompares++; $display("FAIL fast_al_idle: got %h want %h", got, {8'hFF, 4'h0});
        end
    endtask

    task automatic test_random();
        logic [11:0] got_a, got_b;
        for (int i = 0; i < 400; i++) begin
            bus_a.en = ($urandom_range(0, 9) != 0);
            bus_a.mode = ($urandom_range(0, 3) != 0);
            bus_a.x = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 7) == 0) bus_a.scan_last = 3'($urandom_range(0, 7));
            bus_b.en = ($urandom_range(0, 9) != 0);
            bus_b.mode = ($urandom_range(0, 3) != 0);
            bus_b.x = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 7) == 0) bus_b.scan_last = 3'($urandom_range(0, 7));
            tick();
            got_a = {bus_a.y, bus_a.idx, bus_a.wrap};
            got_b = {bus_b.y, bus_b.idx, bus_b.wrap};
            vectors++;
            if (got_a !== expect_of(0)) begin
                miscompares++; $display("FAIL rand_a cyc %0d: got %h want %h", i, got_a, expect_of(0));
            end
            vectors++;
            if (got_b !== expect_of(1)) begin
                miscompares++; $display("FAIL rand_b cyc %0d: got %h want %h", i, got_b, expect_of(1));
            end
        end
    endtask

    initial begin
        test_reset();
        test_direct();
        test_scan_full();
        test_limit();
        test_mode_en();
        test_fast_active_low();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
